timer_pwm_multi: RTL and testbench
==================================

// Module: timer_pwm_multi
// PURPOSE
//   Parametrised N-channel timer/PWM generator. One shared counter with a selectable tick source
//   (stop, clk, prescaled clk, synchronised external tick). Supports Normal, Fast PWM and
//   Phase-Correct modes. TOP, compare values and mode are double-buffered so updates are
//   glitch-free, and a sticky period interrupt is provided. Next-generation peripheral timer
//   for the SoC bus-mapped register block.
// PARAMETERS
//   WIDTH     32   counter, TOP and compare width
//   NCH       2    number of PWM channels
//   PRESCALE  8    clk division when TMR_SRC=2'b10 (>=1)
// PORTS
//   clk              in   1          system clock, rising edge
//   reset            in   1          asynchronous, active-low reset
//   TMR_SRC          in   2          00 stop, 01 clk, 10 clk/PRESCALE, 11 ext_tick rising edge
//   TMR_MODE         in   2          00 Normal, 01 Fast PWM, 10 Phase-Correct, 11 hold
//   TIMER_TOP        in   WIDTH      period limit (buffered)
//   PWM_CNT          in   NCH*WIDTH  compare value for channel i at [i*WIDTH +: WIDTH] (buffered)
//   ext_tick         in   1          asynchronous external count source
//   irq_clr          in   1          one-cycle pulse; clears timer_interrupt
//   PWM_OUT          out  NCH        PWM/toggle outputs, registered
//   timer_interrupt  out  1          sticky period-boundary flag, registered
//   count            out  WIDTH      current counter value
// BEHAVIOUR
//   - Reset (low): count=0, dir=up, prescaler=0, sync flops=0, PWM_OUT=0, timer_interrupt=0.
//     Shadows load TOP=TIMER_TOP, cmp=PWM_CNT, mode=TMR_MODE on the first clk after release.
//     Reset mid-period aborts it immediately; there is no partial state.
//   - tick: SRC 00 never fires. SRC 01 fires every cycle. SRC 10 fires when prescaler==PRESCALE-1;
//     the prescaler wraps to 0 and free-runs only while SRC=10. SRC 11 uses a 2-flop synchroniser
//     plus an edge flop; tick fires 3 clks after an ext_tick rise. SRC changes take effect the next cycle.
//   - The counter advances only on tick. All updates are synchronous to clk.
//   - Normal / Fast (mode 00/01): count 0..TOP, then 0. At wrap (count==TOP and tick):
//     boundary=1.
//   - Phase-Correct (10): dir up, 0..TOP; at TOP dir=down, TOP..0; at 0 dir=up.
//     TOP and 0 are each held for exactly one tick. boundary=1 at the tick that leaves 0
//     going up (bottom).
//   - Mode 11: counter and outputs hold. boundary never fires.
//   - Shadow update: on boundary, load TIMER_TOP, PWM_CNT and TMR_MODE into the shadows.
//     A mode switch via shadow restarts the counter at 0 with dir=up. While SRC=00, the
//     shadows load every cycle (configure-while-stopped).
//   - Fast / Phase-Correct outputs: PWM_OUT[i] = (next_count < cmp[i]). Registered from the
//     next value, so the output matches count in the same cycle. cmp=0 -> constant 0;
//     cmp>TOP -> constant 1.
//   - Normal output: PWM_OUT[i] toggles on the tick where next_count==cmp[i]. If cmp>TOP it
//     never toggles.
//   - TOP=0: count stays 0 and boundary fires every tick. Phase-Correct treats 0 as both
//     TOP and bottom.
//   - Width: all compares are unsigned WIDTH-bit. TOP=2^WIDTH-1 wraps without overflow error.
//   - timer_interrupt: set on boundary, cleared by irq_clr. A simultaneous set and clear
//     leaves it SET.
// TESTING
//   1 SRC=01, mode 00, TOP=9, cmp0=4: count 0..9 wraps every 10 clks; PWM_OUT[0] toggles
//     each period at count 4; IRQ sets each wrap.
//   2 Mode 01, TOP=255, cmp0=0x50, cmp1=0xA0: PWM_OUT[0] high 80/256 clks, PWM_OUT[1] high
//     160/256; cmp=0 gives 0, cmp=300 gives 1.
//   3 Mode 10, TOP=4, cmp0=2: count 0,1,2,3,4,3,2,1,0,...; period 8 ticks; PWM_OUT[0] high
//     while count<2, symmetric; IRQ once per period.
//   4 Shadowing: change TIMER_TOP 9->5 at count 3; the current period still ends at 9,
//     the next period ends at 5; change cmp mid-period with no glitch.
//   5 SRC=10, PRESCALE=8: count increments every 8 clks. SRC=11 ext_tick pulses: one
//     increment per rise, 3-clk latency.
//   6 irq_clr asserted in the same cycle as a wrap: IRQ stays 1. Assert reset low
//     mid-period (async, between edges): all outputs 0 immediately.

Source files
------------

// File: rtl/timer_pwm_multi.sv
// N-channel timer/PWM generator: one shared counter, selectable tick source,
// Normal / Fast PWM / Phase-Correct modes with double-buffered TOP, compare and mode.
module timer_pwm_multi #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 2,
    parameter int PRESCALE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           TMR_SRC,
    input  logic [1:0]           TMR_MODE,
    input  logic [WIDTH-1:0]     TIMER_TOP,
    input  logic [NCH*WIDTH-1:0] PWM_CNT,
    input  logic                 ext_tick,
    input  logic                 irq_clr,
    output logic [NCH-1:0]       PWM_OUT,
    output logic                 timer_interrupt,
    output logic [WIDTH-1:0]     count
);

    // mode | meaning
    // 00   | normal: 0..TOP wrap, outputs toggle on compare match
    // 01   | fast pwm: 0..TOP wrap, output = count < cmp
    // 10   | phase-correct: 0..TOP..0, output = count < cmp
    // 11   | hold: counter and outputs frozen
    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FAST   = 2'b01;
    localparam logic [1:0] MODE_PC     = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [1:0] SRC_STOP = 2'b00;
    localparam logic [1:0] SRC_CLK  = 2'b01;
    localparam logic [1:0] SRC_PRE  = 2'b10;
    localparam logic [1:0] SRC_EXT  = 2'b11;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     top_sh;
    logic [NCH*WIDTH-1:0] cmp_sh;
    logic [1:0]           mode_sh;
    logic                 loaded;
    logic                 dir_up;
    logic [PW-1:0]        presc;
    logic                 sync1, sync2, edge_q;

    logic                 tick_raw, tick, adv, boundary, load, dir_n;
    logic [WIDTH-1:0]     count_n;
    logic [1:0]           mode_eff;
    logic [NCH*WIDTH-1:0] cmp_eff;
    logic [NCH-1:0]       pwm_n;

    always_comb begin
        case (TMR_SRC)
            SRC_CLK: tick_raw = 1'b1;
            SRC_PRE: tick_raw = (presc == PRESC_LAST);
            SRC_EXT: tick_raw = sync2 & ~edge_q;
            default: tick_raw = 1'b0;
        endcase
    end

    // the first clock after reset only loads the shadows; counting starts afterwards
    assign tick = loaded & tick_raw;
    assign adv  = tick & (mode_sh != MODE_HOLD);

    always_comb begin
        boundary = 1'b0;
        count_n  = count;
        dir_n    = dir_up;
        if (adv) begin
            if (mode_sh == MODE_PC) begin
                if (count == '0) begin
                    count_n  = (top_sh == '0) ? '0 : ONE;
                    dir_n    = 1'b1;
                    boundary = 1'b1;
                end else if (dir_up && (count < top_sh)) begin
                    count_n = count + ONE;
                end else begin
                    count_n = count - ONE;
                    dir_n   = 1'b0;
                end
            end else begin
                if (count >= top_sh) begin
                    count_n  = '0;
                    boundary = 1'b1;
                end else begin
                    count_n = count + ONE;
                end
            end
        end
        load     = ~loaded | boundary | (TMR_SRC == SRC_STOP);
        mode_eff = load ? TMR_MODE : mode_sh;
        cmp_eff  = load ? PWM_CNT : cmp_sh;
        if (load && (TMR_MODE != mode_sh)) begin
            count_n = '0;
            dir_n   = 1'b1;
        end
    end

    // outputs are computed from the values the next period will use, so they track count
    always_comb begin
        pwm_n = PWM_OUT;
        for (int i = 0; i < NCH; i++) begin
            case (mode_eff)
                MODE_NORMAL: if (adv && (count_n == cmp_eff[i*WIDTH +: WIDTH])) pwm_n[i] = ~PWM_OUT[i];
                MODE_FAST,
                MODE_PC:     pwm_n[i] = (count_n < cmp_eff[i*WIDTH +: WIDTH]);
                default:     pwm_n[i] = PWM_OUT[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count           <= '0;
            dir_up          <= 1'b1;
            presc           <= '0;
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            edge_q          <= 1'b0;
            PWM_OUT         <= '0;
            timer_interrupt <= 1'b0;
            top_sh          <= '0;
            cmp_sh          <= '0;
            mode_sh         <= MODE_NORMAL;
            loaded          <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (load) begin
                top_sh  <= TIMER_TOP;
                cmp_sh  <= PWM_CNT;
                mode_sh <= TMR_MODE;
            end
            count           <= count_n;
            dir_up          <= dir_n;
            PWM_OUT         <= pwm_n;
            timer_interrupt <= boundary | (timer_interrupt & ~irq_clr);
            sync1           <= ext_tick;
            sync2           <= sync1;
            edge_q          <= sync2;
            if (TMR_SRC == SRC_PRE)
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            else
                presc <= '0;
        end
    end

endmodule

// File: tb/tb_timer_pwm_multi.sv
// Directed bench for timer_pwm_multi: vector tables plus hand-written multi-cycle sequences.
module tb_timer_pwm_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  src = 2'b00;
    logic [1:0]  mode = 2'b00;
    logic [31:0] top = 32'd0;
    logic [63:0] pwm_cnt = 64'd0;
    logic        ext = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  pwm;
    logic        irq;
    logic [31:0] count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  src;
        logic        clr;
        logic [31:0] cnt;
        logic [1:0]  pwm;
        logic        irq;
    } vec_t;

    vec_t pc_tbl[17];
    vec_t z_tbl[4];

    timer_pwm_multi #(.WIDTH(32), .NCH(2), .PRESCALE(8)) dut (
        .clk(clk), .reset(reset), .TMR_SRC(src), .TMR_MODE(mode),
        .TIMER_TOP(top), .PWM_CNT(pwm_cnt), .ext_tick(ext), .irq_clr(clr),
        .PWM_OUT(pwm), .timer_interrupt(irq), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, ".count"}, count, 0);
        chk({name, ".pwm"}, pwm, 0);
        chk({name, ".irq"}, irq, 0);
    endtask

    task automatic restart(input logic [1:0] m, input logic [31:0] t, input logic [31:0] c0, input logic [31:0] c1);
        reset = 1'b0;
        #1;
        check_zero("rst");
        src = 2'b00; mode = m; top = t; pwm_cnt = {c1, c0}; clr = 1'b0; ext = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
    endtask

    function automatic vec_t v(input logic [1:0] s, input logic c, input logic [31:0] cn,
                               input logic [1:0] p, input logic i);
        vec_t r;
        r.src = s; r.clr = c; r.cnt = cn; r.pwm = p; r.irq = i;
        return r;
    endfunction

    initial begin
        // phase-correct, TOP=4, cmp0=2, cmp1=5 (>TOP, stays high); irq_clr at k=2 and k=10
        pc_tbl[0]  = v(2'b01, 0, 1, 2'b11, 1);
        pc_tbl[1]  = v(2'b01, 1, 2, 2'b10, 0);
        pc_tbl[2]  = v(2'b01, 0, 3, 2'b10, 0);
        pc_tbl[3]  = v(2'b01, 0, 4, 2'b10, 0);
        pc_tbl[4]  = v(2'b01, 0, 3, 2'b10, 0);
        pc_tbl[5]  = v(2'b01, 0, 2, 2'b10, 0);
        pc_tbl[6]  = v(2'b01, 0, 1, 2'b11, 0);
        pc_tbl[7]  = v(2'b01, 0, 0, 2'b11, 0);
        pc_tbl[8]  = v(2'b01, 0, 1, 2'b11, 1);
        pc_tbl[9]  = v(2'b01, 1, 2, 2'b10, 0);
        pc_tbl[10] = v(2'b01, 0, 3, 2'b10, 0);
        pc_tbl[11] = v(2'b01, 0, 4, 2'b10, 0);
        pc_tbl[12] = v(2'b01, 0, 3, 2'b10, 0);
        pc_tbl[13] = v(2'b01, 0, 2, 2'b10, 0);
        pc_tbl[14] = v(2'b01, 0, 1, 2'b11, 0);
        pc_tbl[15] = v(2'b01, 0, 0, 2'b11, 0);
        pc_tbl[16] = v(2'b01, 0, 1, 2'b11, 1);
        // normal, TOP=0, cmp0=0 (toggles every tick), cmp1=1; clear held high, set wins
        z_tbl[0] = v(2'b01, 1, 0, 2'b01, 1);
        z_tbl[1] = v(2'b01, 1, 0, 2'b00, 1);
        z_tbl[2] = v(2'b01, 1, 0, 2'b01, 1);
        z_tbl[3] = v(2'b00, 1, 0, 2'b01, 0);

        step();
        step();
        check_zero("reset_hold");

        // normal mode, TOP=9, cmp0=4, cmp1=20 (never reached)
        restart(2'b00, 32'd9, 32'd4, 32'd20);
        chk("norm_cfg.count", count, 0);
        for (int k = 1; k <= 32; k++) begin
            src = 2'b01;
            clr = (k == 12) || (k == 21) || (k == 30);
            step();
            chk($sformatf("norm[%0d].count", k), count, k % 10);
            chk($sformatf("norm[%0d].pwm", k), pwm, ((k >= 4 && k < 14) || k >= 24) ? 2'b01 : 2'b00);
            chk($sformatf("norm[%0d].irq", k), irq, ((k >= 10 && k < 12) || k == 20 || k >= 30) ? 1 : 0);
        end
        // shadowing: TOP 9->5 and cmp0 4->7 written while count=3
        for (int k = 33; k <= 47; k++) begin
            if (k == 34) begin
                top = 32'd5;
                pwm_cnt = {32'd20, 32'd7};
            end
            clr = (k == 35) || (k == 41);
            step();
            chk($sformatf("shadow[%0d].count", k), count, (k <= 40) ? (k % 10) : ((k - 40) % 6));
            chk($sformatf("shadow[%0d].pwm", k), pwm, (k == 33) ? 2'b01 : 2'b00);
            chk($sformatf("shadow[%0d].irq", k), irq,
                (k <= 34 || k == 40 || k >= 46) ? 1 : 0);
        end
        clr = 1'b0;

        // fast PWM, TOP=255, cmp0=0x50, cmp1=0xA0; compares become 0/300 at the period after k=257
        restart(2'b01, 32'd255, 32'h50, 32'hA0);
        chk("fast_cfg.pwm", pwm, 2'b11);
        begin
            int ha0, ha1, hb0, hb1, hc0, hc1;
            ha0 = 0; ha1 = 0; hb0 = 0; hb1 = 0; hc0 = 0; hc1 = 0;
            for (int k = 1; k <= 767; k++) begin
                src = 2'b01;
                if (k == 257) pwm_cnt = {32'd300, 32'd0};
                step();
                if (k % 64 == 0) chk($sformatf("fast[%0d].count", k), count, k % 256);
                if (k <= 256) begin ha0 += int'(pwm[0]); ha1 += int'(pwm[1]); end
                else if (k <= 511) begin hb0 += int'(pwm[0]); hb1 += int'(pwm[1]); end
                else begin hc0 += int'(pwm[0]); hc1 += int'(pwm[1]); end
            end
            chk("fast_a.high0", ha0, 80);
            chk("fast_a.high1", ha1, 160);
            chk("fast_b.high0", hb0, 79);
            chk("fast_b.high1", hb1, 159);
            chk("fast_c.high0", hc0, 0);
            chk("fast_c.high1", hc1, 256);
        end

        restart(2'b10, 32'd4, 32'd2, 32'd5);
        chk("pc_cfg.pwm", pwm, 2'b11);
        for (int i = 0; i < 17; i++) begin
            src = pc_tbl[i].src;
            clr = pc_tbl[i].clr;
            step();
            chk($sformatf("pc[%0d].count", i), count, pc_tbl[i].cnt);
            chk($sformatf("pc[%0d].pwm", i), pwm, pc_tbl[i].pwm);
            chk($sformatf("pc[%0d].irq", i), irq, pc_tbl[i].irq);
        end
        clr = 1'b0;
        // asynchronous reset between edges, mid-period
        reset = 1'b0;
        #1;
        check_zero("async_rst");

        restart(2'b00, 32'd0, 32'd0, 32'd1);
        for (int i = 0; i < 4; i++) begin
            src = z_tbl[i].src;
            clr = z_tbl[i].clr;
            step();
            chk($sformatf("top0[%0d].count", i), count, z_tbl[i].cnt);
            chk($sformatf("top0[%0d].pwm", i), pwm, z_tbl[i].pwm);
            chk($sformatf("top0[%0d].irq", i), irq, z_tbl[i].irq);
        end
        clr = 1'b0;

        // prescaled clock, then synchronised external tick
        restart(2'b00, 32'd100, 32'd50, 32'd60);
        for (int j = 1; j <= 24; j++) begin
            src = 2'b10;
            step();
            chk($sformatf("presc[%0d].count", j), count, j / 8);
        end
        src = 2'b11;
        step();
        step();
        chk("ext_idle.count", count, 3);
        for (int p = 0; p < 2; p++) begin
            ext = 1'b1;
            step();
            chk($sformatf("ext%0d_lat1.count", p), count, 3 + p);
            step();
            chk($sformatf("ext%0d_lat2.count", p), count, 3 + p);
            step();
            chk($sformatf("ext%0d_lat3.count", p), count, 4 + p);
            step();
            step();
            step();
            chk($sformatf("ext%0d_held.count", p), count, 4 + p);
            ext = 1'b0;
            step();
            step();
            step();
            step();
            chk($sformatf("ext%0d_low.count", p), count, 4 + p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
